lspc_vram_arbiter: RTL and testbench

//  Time-slot arbiter sharing the LSPC VRAM port between fix-map fetch, sprite fetch and 68k CPU access.
//  - Slots are derived from the video sync pixel counter. Each pixel is one slot of 4 CLK_24M cycles.
//  - Sits between the video sync counters, the fix/sprite render fetchers and the CPU VRAM register interface.
//  - Guarantees the fix fetcher a fixed slot and bounds CPU wait latency.

---
 rtl/lspc_pkg.sv | 34 +++
 rtl/lspc_slot_phase.sv | 33 +++
 rtl/lspc_vram_arbiter.sv | 115 +++++++++++
 tb/tb_lspc_vram_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lspc_pkg.sv
// rtl/lspc_pkg.sv - shared types, constants and owner priority for the LSPC VRAM arbiter
package lspc_pkg;

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_FIX  = 2'd1,
      OWN_SPR  = 2'd2,
      OWN_CPU  = 2'd3
   } owner_t;

   localparam logic [1:0] PH_ADDR      = 2'd0;
   localparam logic [1:0] PH_CAP       = 2'd3;
   localparam logic [2:0] DEF_FIX_SLOT = 3'd0;
   localparam logic [2:0] DEF_CPU_SLOT = 3'd4;

   // The fix slot is only reserved during active display; in blanking the CPU gets first pick.
   function automatic owner_t pick_owner(input logic vblank, input logic fix_slot,
                                         input logic cpu_slot, input logic fix_req,
                                         input logic spr_req, input logic cpu_req);
      owner_t own;
      own = OWN_IDLE;
      if (!vblank && fix_slot) begin
         if (fix_req) own = OWN_FIX;
      end else if (vblank || cpu_slot) begin
         if (cpu_req)      own = OWN_CPU;
         else if (spr_req) own = OWN_SPR;
      end else begin
         if (spr_req)      own = OWN_SPR;
         else if (cpu_req) own = OWN_CPU;
      end
      return own;
   endfunction

endpackage

// File: rtl/lspc_slot_phase.sv
// rtl/lspc_slot_phase.sv - recovers the 4-clock pixel phase and slot index from the sync pixel counter
module lspc_slot_phase
   import lspc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] h_count,
   output logic [1:0] phase,
   output logic [2:0] slot,
   output logic       ph0
);

   logic [8:0] hcnt_q;
   logic [1:0] phase_q;
   logic       changed;

   assign changed = (h_count != hcnt_q);
   assign phase   = changed ? PH_ADDR : phase_q;
   assign ph0     = (phase == PH_ADDR);
   assign slot    = h_count[2:0];

   // A frozen counter lets phase_q wrap on its own, so slots keep running on the same index.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q  <= '0;
         phase_q <= '0;
      end else begin
         hcnt_q  <= h_count;
         phase_q <= changed ? 2'd1 : phase_q + 2'd1;
      end
   end

endmodule

// File: rtl/lspc_vram_arbiter.sv
// rtl/lspc_vram_arbiter.sv - time-slot arbiter sharing the LSPC VRAM port between fix, sprite and CPU
module lspc_vram_arbiter
   import lspc_pkg::*;
#(
   parameter int         ADDR_W   = 16,
   parameter int         DATA_W   = 16,
   parameter logic [2:0] FIX_SLOT = DEF_FIX_SLOT,
   parameter logic [2:0] CPU_SLOT = DEF_CPU_SLOT
) (
   input  logic              CLK_24M,
   input  logic              nRESETP,
   input  logic [8:0]        H_COUNT,
   input  logic              VBLANK,
   input  logic              FIX_REQ,
   input  logic [ADDR_W-1:0] FIX_ADDR,
   output logic              FIX_VALID,
   output logic [DATA_W-1:0] FIX_RDATA,
   input  logic              SPR_REQ,
   input  logic [ADDR_W-1:0] SPR_ADDR,
   output logic              SPR_VALID,
   output logic [DATA_W-1:0] SPR_RDATA,
   input  logic              CPU_REQ,
   input  logic              CPU_WE,
   input  logic [ADDR_W-1:0] CPU_ADDR,
   input  logic [DATA_W-1:0] CPU_WDATA,
   output logic              CPU_ACK,
   output logic [DATA_W-1:0] CPU_RDATA,
   output logic [ADDR_W-1:0] VRAM_ADDR,
   output logic [DATA_W-1:0] VRAM_DOUT,
   output logic              VRAM_WE,
   input  logic [DATA_W-1:0] VRAM_DIN,
   output logic [1:0]        OWNER
);

   logic [1:0] phase;
   logic [2:0] slot;
   logic       ph0;
   owner_t     owner_q;
   owner_t     next_owner;
   logic       cpu_we_q;

   lspc_slot_phase u_phase (
      .clk     (CLK_24M),
      .rst_n   (nRESETP),
      .h_count (H_COUNT),
      .phase   (phase),
      .slot    (slot),
      .ph0     (ph0)
   );

   assign next_owner = pick_owner(VBLANK, slot == FIX_SLOT, slot == CPU_SLOT,
                                  FIX_REQ, SPR_REQ, CPU_REQ);
   assign OWNER      = owner_q;

   always_ff @(negedge CLK_24M or negedge nRESETP) begin
      if (!nRESETP) begin
         owner_q   <= OWN_IDLE;
         cpu_we_q  <= 1'b0;
         VRAM_ADDR <= '0;
         VRAM_DOUT <= '0;
         VRAM_WE   <= 1'b0;
         FIX_VALID <= 1'b0;
         FIX_RDATA <= '0;
         SPR_VALID <= 1'b0;
         SPR_RDATA <= '0;
         CPU_ACK   <= 1'b0;
         CPU_RDATA <= '0;
      end else begin
         FIX_VALID <= 1'b0;
         SPR_VALID <= 1'b0;
         CPU_ACK   <= 1'b0;
         if (ph0) begin
            owner_q  <= next_owner;
            cpu_we_q <= (next_owner == OWN_CPU) && CPU_WE;
            VRAM_WE  <= (next_owner == OWN_CPU) && CPU_WE;
            case (next_owner)
               OWN_FIX: begin
                  VRAM_ADDR <= FIX_ADDR;
                  VRAM_DOUT <= '0;
               end
               OWN_SPR: begin
                  VRAM_ADDR <= SPR_ADDR;
                  VRAM_DOUT <= '0;
               end
               OWN_CPU: begin
                  VRAM_ADDR <= CPU_ADDR;
                  VRAM_DOUT <= CPU_WDATA;
               end
               default: ;
            endcase
         end else begin
            // Strobe spans ph1-ph2 and is already low while the read data settles in ph3.
            VRAM_WE <= (phase == 2'd1) && (owner_q == OWN_CPU) && cpu_we_q;
            if (phase == PH_CAP) begin
               case (owner_q)
                  OWN_FIX: begin
                     FIX_VALID <= 1'b1;
                     FIX_RDATA <= VRAM_DIN;
                  end
                  OWN_SPR: begin
                     SPR_VALID <= 1'b1;
                     SPR_RDATA <= VRAM_DIN;
                  end
                  OWN_CPU: begin
                     CPU_ACK <= 1'b1;
                     if (!cpu_we_q) CPU_RDATA <= VRAM_DIN;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_lspc_vram_arbiter.sv
// tb/tb_lspc_vram_arbiter.sv - self-checking bench for lspc_vram_arbiter
module tb_lspc_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [8:0]  h_count = '0;
   logic        vblank = 1'b0;
   logic        fix_req = 1'b0;
   logic [15:0] fix_addr = '0;
   logic        spr_req = 1'b0;
   logic [15:0] spr_addr = '0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] vram_din = 16'hA5A5;
   logic        din_hold = 1'b0;

   logic        fix_valid, spr_valid, cpu_ack, vram_we;
   logic [15:0] fix_rdata, spr_rdata, cpu_rdata, vram_addr, vram_dout;
   logic [1:0]  owner;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   lspc_vram_arbiter dut (
      .CLK_24M   (clk),
      .nRESETP   (rst_n),
      .H_COUNT   (h_count),
      .VBLANK    (vblank),
      .FIX_REQ   (fix_req),
      .FIX_ADDR  (fix_addr),
      .FIX_VALID (fix_valid),
      .FIX_RDATA (fix_rdata),
      .SPR_REQ   (spr_req),
      .SPR_ADDR  (spr_addr),
      .SPR_VALID (spr_valid),
      .SPR_RDATA (spr_rdata),
      .CPU_REQ   (cpu_req),
      .CPU_WE    (cpu_we),
      .CPU_ADDR  (cpu_addr),
      .CPU_WDATA (cpu_wdata),
      .CPU_ACK   (cpu_ack),
      .CPU_RDATA (cpu_rdata),
      .VRAM_ADDR (vram_addr),
      .VRAM_DOUT (vram_dout),
      .VRAM_WE   (vram_we),
      .VRAM_DIN  (vram_din),
      .OWNER     (owner)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Slot ownership straight from the priority table: 0 idle, 1 fix, 2 sprite, 3 cpu.
   function automatic int decide(input bit vb, input bit [2:0] s, input bit f,
                                 input bit sp, input bit c);
      if (vb)     return c ? 3 : (sp ? 2 : 0);
      if (s == 0) return f ? 1 : 0;
      if (s == 4) return c ? 3 : (sp ? 2 : 0);
      return sp ? 2 : (c ? 3 : 0);
   endfunction

   // Model: a slot opens on a pixel-counter change (or every 4th clock if frozen); the owner
   // shows one clock later, a cpu write strobes for the next two clocks, and the data seen in
   // the slot's fourth clock comes back as a single pulse one clock after that.
   int          m_owner = 0, m_age = 0, m_ph = 0;
   bit          m_we = 1'b0;
   logic [8:0]  m_prev_h = '0;
   int          e_owner = 0;
   logic [15:0] e_addr = '0, e_dout = '0, e_fd = '0, e_sd = '0, e_cd = '0;
   bit          e_we = 1'b0, e_fv = 1'b0, e_sv = 1'b0, e_ack = 1'b0;

   always @(negedge clk) begin
      bit ph0;
      if (!rst_n) begin
         m_owner = 0; m_age = 0; m_ph = 0; m_we = 1'b0; m_prev_h = '0;
         e_owner = 0; e_addr = '0; e_dout = '0; e_fd = '0; e_sd = '0; e_cd = '0;
         e_we = 1'b0; e_fv = 1'b0; e_sv = 1'b0; e_ack = 1'b0;
      end else begin
         ph0 = (h_count != m_prev_h) || (m_ph == 0);
         m_prev_h = h_count;
         m_ph = ph0 ? 1 : (m_ph + 1) % 4;
         e_fv = 1'b0; e_sv = 1'b0; e_ack = 1'b0; e_we = 1'b0;
         if (ph0) begin
            m_owner = decide(vblank, h_count[2:0], fix_req, spr_req, cpu_req);
            m_age = 0;
            m_we = (m_owner == 3) && cpu_we;
            e_owner = m_owner;
            e_we = m_we;
            if (m_owner == 1) begin e_addr = fix_addr; e_dout = '0; end
            if (m_owner == 2) begin e_addr = spr_addr; e_dout = '0; end
            if (m_owner == 3) begin e_addr = cpu_addr; e_dout = cpu_wdata; end
         end else begin
            m_age++;
            e_we = (m_owner == 3) && m_we && (m_age == 1);
            if (m_age == 3) begin
               if (m_owner == 1) begin e_fv = 1'b1; e_fd = vram_din; end
               if (m_owner == 2) begin e_sv = 1'b1; e_sd = vram_din; end
               if (m_owner == 3) begin
                  e_ack = 1'b1;
                  if (!m_we) e_cd = vram_din;
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (cmp_en) begin
         chk("owner", 32'(owner), 32'(e_owner));
         chk("vram_addr", 32'(vram_addr), 32'(e_addr));
         chk("vram_dout", 32'(vram_dout), 32'(e_dout));
         chk("vram_we", 32'(vram_we), 32'(e_we));
         chk("fix_valid", 32'(fix_valid), 32'(e_fv));
         chk("fix_rdata", 32'(fix_rdata), 32'(e_fd));
         chk("spr_valid", 32'(spr_valid), 32'(e_sv));
         chk("spr_rdata", 32'(spr_rdata), 32'(e_sd));
         chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
         chk("cpu_rdata", 32'(cpu_rdata), 32'(e_cd));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (!din_hold) vram_din = vram_din + 16'h1357;
      end
   endtask

   task automatic pixel(input int h);
      h_count = 9'(h);
      cyc(4);
   endtask

   int own_seen[8];
   int exp_own[8];
   int we_cnt;
   int k;

   initial begin
      exp_own = '{0, 2, 2, 2, 3, 2, 2, 2};
      spr_addr = 16'h3300;
      #2 rst_n = 1'b0;
      cyc(3);
      cmp_en = 1'b1;
      rst_n = 1'b1;
      for (int h = 1; h <= 7; h++) pixel(h);

      // Fix fetch in its reserved slot
      fix_req = 1'b1; fix_addr = 16'h7000; din_hold = 1'b1; vram_din = 16'hBEEF;
      h_count = 9'd8;
      cyc(1);
      chk("t2_owner_fix", 32'(owner), 32'd1);
      chk("t2_addr", 32'(vram_addr), 32'h7000);
      cyc(3);
      chk("t2_fix_valid", 32'(fix_valid), 32'd1);
      chk("t2_fix_rdata", 32'(fix_rdata), 32'hBEEF);
      fix_req = 1'b0; din_hold = 1'b0;
      for (int h = 9; h <= 15; h++) pixel(h);

      // Sprite and CPU contending across a whole 8-slot group
      spr_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0456;
      for (int s = 0; s < 8; s++) begin
         h_count = 9'(16 + s);
         cyc(1);
         own_seen[s] = int'(owner);
         cyc(3);
      end
      for (int s = 0; s < 8; s++) chk($sformatf("t3_slot%0d_owner", s), 32'(own_seen[s]), 32'(exp_own[s]));
      cpu_req = 1'b0; spr_req = 1'b0;
      pixel(24);
      pixel(25);

      // CPU write in blanking beats the sprite; late changes to the CPU inputs are ignored
      vblank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8200; cpu_wdata = 16'h1234;
      spr_req = 1'b1;
      h_count = 9'd26;
      we_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (vram_we) we_cnt++;
         if (i == 0) begin
            chk("t4_owner_cpu", 32'(owner), 32'd3);
            chk("t4_addr", 32'(vram_addr), 32'h8200);
            chk("t4_dout", 32'(vram_dout), 32'h1234);
            cpu_addr = 16'hFFFF; cpu_wdata = 16'h0000; cpu_we = 1'b0; spr_req = 1'b0;
         end
         if (i == 1) vblank = 1'b0;
      end
      chk("t4_we_clocks", 32'(we_cnt), 32'd2);
      chk("t4_ack", 32'(cpu_ack), 32'd1);
      cpu_req = 1'b0;
      pixel(27);

      // CPU request arriving just after a slot-5 grant waits for the next CPU slot
      spr_req = 1'b1; spr_addr = 16'h3310;
      pixel(28);
      h_count = 9'd29;
      cyc(1);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
      k = 1;
      while (k < 64) begin
         cyc(1);
         k++;
         if (k % 4 == 0) h_count = h_count + 9'd1;
         if (cpu_ack) break;
      end
      chk("t5_ack_clocks", 32'(k), 32'd32);
      chk("t5_h_at_ack", 32'(h_count), 32'd37);
      cpu_req = 1'b0;

      // Pixel counter wrap 383 -> 0 keeps the slot pattern
      pixel(380);
      pixel(381);
      pixel(382);
      fix_req = 1'b1; fix_addr = 16'h0040;
      h_count = 9'd383;
      cyc(1);
      chk("t6_slot7_owner", 32'(owner), 32'd2);
      cyc(3);
      h_count = 9'd0;
      cyc(1);
      chk("t6_slot0_owner", 32'(owner), 32'd1);
      chk("t6_slot0_addr", 32'(vram_addr), 32'h0040);
      cyc(3);
      h_count = 9'd1;
      cyc(1);
      chk("t6_slot1_owner", 32'(owner), 32'd2);
      cyc(3);

      // Reset landing mid-write drops the strobe at once and aborts the slot
      fix_req = 1'b0; spr_req = 1'b0;
      vblank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8300; cpu_wdata = 16'h5678;
      h_count = 9'd2;
      cyc(1);
      chk("t1_we_before", 32'(vram_we), 32'd1);
      cyc(1);
      rst_n = 1'b0;
      #1;
      chk("t1_we_async", 32'(vram_we), 32'd0);
      chk("t1_owner", 32'(owner), 32'd0);
      chk("t1_addr", 32'(vram_addr), 32'd0);
      chk("t1_fix_rdata", 32'(fix_rdata), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("t1_no_ack", 32'(cpu_ack), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
